// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Multi-cycle control sequencer upstream of the register file / datapath.
//   Accepts one register-transfer command per start handshake (sampled only
//   in IDLE) and drives the datapath controls cycle by cycle, ending each
//   command with a one-cycle done pulse.  All outputs are registered.
//
//   Ports:
//     clk, reset             rising-edge clock, async active-high reset
//     start, op, rd, rn, rm  command handshake and fields
//     shift_in, imm_in       B-operand shift code and MOVI immediate
//     busy, done, err        status (err only meaningful with the macro)
//     readnum, writenum      register-file read/write addresses (binary)
//     write                  register-file write strobe
//     loada/b/c, loads       A/B/C/status load enables
//     asel                   1 = A operand forced to zero
//     vsel                   one-hot writeback select (01 = C, 10 = imm)
//     aluop                  00 add, 01 sub, 10 and, 11 not-B
//     shift, imm             latched shift_in / imm_in
//
//   Build option: SEQ_ILLEGAL_OP_EN -- when defined, opcodes 110/111 spend
//   one cycle in ILL with err=1, done=1; otherwise they run as MOVI and err
//   is tied low.
module datapath_sequencer #(
   parameter int RN_W   = 3,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [RN_W-1:0]   rd,
   input  logic [RN_W-1:0]   rn,
   input  logic [RN_W-1:0]   rm,
   input  logic [1:0]        shift_in,
   input  logic [DATA_W-1:0] imm_in,
   output logic              busy,
   output logic              done,
   output logic [RN_W-1:0]   readnum,
   output logic [RN_W-1:0]   writenum,
   output logic              write,
   output logic              loada,
   output logic              loadb,
   output logic              loadc,
   output logic              loads,
   output logic              asel,
   output logic [1:0]        vsel,
   output logic [1:0]        aluop,
   output logic [1:0]        shift,
   output logic [DATA_W-1:0] imm,
   output logic              err
);

   localparam logic [2:0] OP_MOVI = 3'b000, OP_MOV = 3'b001, OP_ADD = 3'b010,
                          OP_CMP  = 3'b011, OP_AND = 3'b100, OP_MVN = 3'b101;

`ifdef SEQ_ILLEGAL_OP_EN
   typedef enum logic [2:0] {IDLE, LA, LB, EX, WB, WIMM, ILL} state_t;
`else
   typedef enum logic [2:0] {IDLE, LA, LB, EX, WB, WIMM} state_t;
`endif

   state_t            state, nxt;
   logic [2:0]        op_q;
   logic [RN_W-1:0]   rd_q, rn_q, rm_q;

   // Command fields seen by the output logic: the live inputs on the accept
   // edge (latches not yet loaded), the latched copies afterwards.
   logic              idle;
   logic [2:0]        c_op;
   logic [RN_W-1:0]   c_rd, c_rn, c_rm;

   assign idle = (state == IDLE);
   assign c_op = idle ? op : op_q;
   assign c_rd = idle ? rd : rd_q;
   assign c_rn = idle ? rn : rn_q;
   assign c_rm = idle ? rm : rm_q;

   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE: begin
            nxt = IDLE;
            if (start) begin
               case (op)
                  OP_MOVI:        nxt = WIMM;
                  OP_MOV, OP_MVN: nxt = LB;
                  OP_ADD, OP_AND,
                  OP_CMP:         nxt = LA;
`ifdef SEQ_ILLEGAL_OP_EN
                  default:        nxt = ILL;
`else
                  default:        nxt = WIMM;
`endif
               endcase
            end
         end
         LA:      nxt = LB;
         LB:      nxt = EX;
         EX:      nxt = (op_q == OP_CMP) ? IDLE : WB;
         default: nxt = IDLE;   // WB, WIMM, ILL all finish in one cycle
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         rn_q     <= '0;
         rm_q     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         readnum  <= '0;
         writenum <= '0;
         write    <= 1'b0;
         loada    <= 1'b0;
         loadb    <= 1'b0;
         loadc    <= 1'b0;
         loads    <= 1'b0;
         asel     <= 1'b0;
         vsel     <= 2'b01;
         aluop    <= 2'b00;
         shift    <= 2'b00;
         imm      <= '0;
`ifdef SEQ_ILLEGAL_OP_EN
         err      <= 1'b0;
`endif
      end else begin
         state <= nxt;
         if (idle && start) begin
            op_q  <= op;
            rd_q  <= rd;
            rn_q  <= rn;
            rm_q  <= rm;
            shift <= shift_in;
            imm   <= imm_in;
         end
         // Outputs are registered for the state being entered; readnum and
         // writenum are left untouched unless that state drives them.
         busy  <= (nxt != IDLE);
         done  <= 1'b0;
         write <= 1'b0;
         loada <= 1'b0;
         loadb <= 1'b0;
         loadc <= 1'b0;
         loads <= 1'b0;
         asel  <= 1'b0;
         vsel  <= 2'b01;
         aluop <= 2'b00;
`ifdef SEQ_ILLEGAL_OP_EN
         err   <= 1'b0;
`endif
         case (nxt)
            LA: begin
               readnum <= c_rn;
               loada   <= 1'b1;
            end
            LB: begin
               readnum <= c_rm;
               loadb   <= 1'b1;
            end
            EX: begin
               case (c_op)
                  OP_CMP:  aluop <= 2'b01;
                  OP_AND:  aluop <= 2'b10;
                  OP_MVN:  aluop <= 2'b11;
                  default: aluop <= 2'b00;
               endcase
               // MOV is computed as 0 + sh(Rm)
               asel <= (c_op == OP_MOV) || (c_op == OP_MVN);
               if (c_op == OP_CMP) begin
                  loads <= 1'b1;
                  done  <= 1'b1;
               end else begin
                  loadc <= 1'b1;
               end
            end
            WB: begin
               writenum <= c_rd;
               write    <= 1'b1;
               done     <= 1'b1;
            end
            WIMM: begin
               writenum <= c_rd;
               vsel     <= 2'b10;
               write    <= 1'b1;
               done     <= 1'b1;
            end
`ifdef SEQ_ILLEGAL_OP_EN
            ILL: begin
               err  <= 1'b1;
               done <= 1'b1;
            end
`endif
            default: ;
         endcase
      end
   end

`ifndef SEQ_ILLEGAL_OP_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: each command pushes its
// hand-computed per-cycle output records; a negedge monitor pops one record
// for every busy cycle and checks idle cycles carry no strobes.
module tb_datapath_sequencer;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  op, rd, rn, rm;
   logic [1:0]  shift_in;
   logic [15:0] imm_in;
   logic        busy, done, write, loada, loadb, loadc, loads, asel, err;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, aluop, shift;
   logic [15:0] imm;

   datapath_sequencer #(.RN_W(3), .DATA_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .rd(rd), .rn(rn),
      .rm(rm), .shift_in(shift_in), .imm_in(imm_in), .busy(busy),
      .done(done), .readnum(readnum), .writenum(writenum), .write(write),
      .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
      .asel(asel), .vsel(vsel), .aluop(aluop), .shift(shift), .imm(imm),
      .err(err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  rn, wn;
      logic        wr, la, lb, lc, ls, as;
      logic [1:0]  vs, al, sh;
      logic [15:0] im;
      logic        dn, er;
   } rec_t;

   rec_t q[$];
   int   n_vec = 0, n_bad = 0;
   logic checking = 1'b0;
   logic [1:0]  g_sh;
   logic [15:0] g_im;

   // Push one expected busy-cycle record; shift/imm come from the command.
   task automatic push(input logic [2:0] r, input logic [2:0] w,
                       input logic wr, la, lb, lc, ls, as,
                       input logic [1:0] vs, input logic [1:0] al,
                       input logic dn, input logic er);
      q.push_back('{rn:r, wn:w, wr:wr, la:la, lb:lb, lc:lc, ls:ls, as:as,
                    vs:vs, al:al, sh:g_sh, im:g_im, dn:dn, er:er});
   endtask

   rec_t act;
   always_comb act = '{rn:readnum, wn:writenum, wr:write, la:loada, lb:loadb,
                       lc:loadc, ls:loads, as:asel, vs:vsel, al:aluop,
                       sh:shift, im:imm, dn:done, er:err};

   always @(negedge clk) begin
      if (checking && !reset) begin
         n_vec++;
         if (busy) begin
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL busy_unexpected: got %h, required no busy cycle", act);
            end else begin
               rec_t e;
               e = q.pop_front();
               if (act !== e) begin
                  n_bad++;
                  $display("FAIL cycle t=%0t: got %h, required %h", $time, act, e);
               end
            end
         end else if ({write, done, loada, loadb, loadc, loads, err} !== 7'b0) begin
            n_bad++;
            $display("FAIL idle_strobes t=%0t: got %b, required 0000000", $time,
                     {write, done, loada, loadb, loadc, loads, err});
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
      n_vec++;
      if (got !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   task automatic set_cmd(input logic [2:0] o, d, n, m, input logic [1:0] s,
                          input logic [15:0] i);
      op = o; rd = d; rn = n; rm = m; shift_in = s; imm_in = i;
      g_sh = s; g_im = i;
   endtask

   // Wait (bounded) for the command to drain and the sequencer to go idle.
   task automatic drain(input string name);
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         if (!busy && q.size() == 0) break;
      end
      check({name, "_drain"}, {63'd0, busy || q.size() != 0}, 64'd0);
   endtask

   task automatic run(input string name);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      drain(name);
   endtask

   localparam logic [63:0] RST_VAL = {35'd0, 3'd0, 3'd0, 2'b01, 2'b00, 2'b00, 1'b0, 16'h0000};

   initial begin
      reset = 1'b1; start = 1'b0;
      set_cmd(3'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_state",
            {35'd0, readnum, writenum, vsel, aluop, shift, asel, imm}, RST_VAL);
      check("reset_strobes", {57'd0, busy, done, write, loada, loadb, loadc, loads, err}, 64'd0);
      checking = 1'b1;

      // MOVI r3 = 00A5
      set_cmd(3'b000, 3'd3, 3'd0, 3'd0, 2'b00, 16'h00A5);
      push(0, 3, 1,0,0,0,0,0, 2'b10, 2'b00, 1, 0);
      run("movi");

      // ADD r5 = r1 + r2
      set_cmd(3'b010, 3'd5, 3'd1, 3'd2, 2'b00, 16'h0000);
      push(1, 3, 0,1,0,0,0,0, 2'b01, 2'b00, 0, 0);
      push(2, 3, 0,0,1,0,0,0, 2'b01, 2'b00, 0, 0);
      push(2, 3, 0,0,0,1,0,0, 2'b01, 2'b00, 0, 0);
      push(2, 5, 1,0,0,0,0,0, 2'b01, 2'b00, 1, 0);
      run("add");

      // CMP r4, r6
      set_cmd(3'b011, 3'd1, 3'd4, 3'd6, 2'b00, 16'h0000);
      push(4, 5, 0,1,0,0,0,0, 2'b01, 2'b00, 0, 0);
      push(6, 5, 0,0,1,0,0,0, 2'b01, 2'b00, 0, 0);
      push(6, 5, 0,0,0,0,1,0, 2'b01, 2'b01, 1, 0);
      run("cmp");

      // MOV r0 = sh(r7), start held high: two back-to-back commands
      set_cmd(3'b001, 3'd0, 3'd3, 3'd7, 2'b01, 16'h0000);
      push(7, 5, 0,0,1,0,0,0, 2'b01, 2'b00, 0, 0);
      push(7, 5, 0,0,0,1,0,1, 2'b01, 2'b00, 0, 0);
      push(7, 0, 1,0,0,0,0,0, 2'b01, 2'b00, 1, 0);
      push(7, 0, 0,0,1,0,0,0, 2'b01, 2'b00, 0, 0);
      push(7, 0, 0,0,0,1,0,1, 2'b01, 2'b00, 0, 0);
      push(7, 0, 1,0,0,0,0,0, 2'b01, 2'b00, 1, 0);
      start = 1'b1;
      repeat (5) @(posedge clk);
      #1 start = 1'b0;
      drain("mov_held");

      // AND r2 = r3 & sh(r1)
      set_cmd(3'b100, 3'd2, 3'd3, 3'd1, 2'b10, 16'h0000);
      push(3, 0, 0,1,0,0,0,0, 2'b01, 2'b00, 0, 0);
      push(1, 0, 0,0,1,0,0,0, 2'b01, 2'b00, 0, 0);
      push(1, 0, 0,0,0,1,0,0, 2'b01, 2'b10, 0, 0);
      push(1, 2, 1,0,0,0,0,0, 2'b01, 2'b00, 1, 0);
      run("and");

      // MVN r6 = ~sh(r4)
      set_cmd(3'b101, 3'd6, 3'd0, 3'd4, 2'b11, 16'h0000);
      push(4, 2, 0,0,1,0,0,0, 2'b01, 2'b00, 0, 0);
      push(4, 2, 0,0,0,1,0,1, 2'b01, 2'b11, 0, 0);
      push(4, 6, 1,0,0,0,0,0, 2'b01, 2'b00, 1, 0);
      run("mvn");

      // ADD interrupted by reset during EX
      set_cmd(3'b010, 3'd5, 3'd1, 3'd2, 2'b00, 16'h0000);
      push(1, 6, 0,1,0,0,0,0, 2'b01, 2'b00, 0, 0);
      push(2, 6, 0,0,1,0,0,0, 2'b01, 2'b00, 0, 0);
      push(2, 6, 0,0,0,1,0,0, 2'b01, 2'b00, 0, 0);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); #2 reset = 1'b1;
      #1;
      check("async_reset_strobes", {57'd0, busy, done, write, loada, loadb, loadc, loads, err}, 64'd0);
      check("async_reset_state",
            {35'd0, readnum, writenum, vsel, aluop, shift, asel, imm}, RST_VAL);
      check("async_reset_queue", {32'd0, 32'(q.size())}, 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      repeat (3) @(negedge clk);

      // Illegal opcode 111
      set_cmd(3'b111, 3'd4, 3'd0, 3'd0, 2'b00, 16'h1234);
`ifdef SEQ_ILLEGAL_OP_EN
      push(0, 0, 0,0,0,0,0,0, 2'b01, 2'b00, 1, 1);
`else
      push(0, 4, 1,0,0,0,0,0, 2'b10, 2'b00, 1, 0);
`endif
      run("illegal");

      repeat (2) @(negedge clk);
      checking = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control sequencer that sits directly upstream of the register file / datapath.
- Accepts one register-transfer command per handshake.
- Drives, cycle by cycle, the datapath controls: read/write register numbers (binary, decoded downstream), A/B/C/status load enables, the A-operand zero select, the one-hot writeback mux select, ALU op and shift.
- Signals completion with a `done` pulse.

Parameters:
- RN_W, 3, width of register-number fields (8 registers).
- DATA_W, 16, datapath width; width of the immediate.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  command valid; sampled only in IDLE
- op  in  3  command opcode
- rd  in  RN_W  destination register
- rn  in  RN_W  first source register
- rm  in  RN_W  second source register
- shift_in  in  2  shift code applied to B operand
- imm_in  in  DATA_W  immediate value for MOVI
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse in the final cycle of a command
- readnum  out  RN_W  register file read address
- writenum  out  RN_W  register file write address
- write  out  1  register file write strobe
- loada, loadb, loadc, loads  out  1 each  A/B/C/status register load enables
- asel  out  1  1 = A operand forced to zero
- vsel  out  2  one-hot writeback select: 01 = C result, 10 = immediate
- aluop  out  2  00 add, 01 subtract, 10 and, 11 not-B
- shift  out  2  latched shift_in
- imm  out  DATA_W  latched imm_in
- err  out  1  illegal-opcode pulse (see Optional Feature)

Behaviour:
- Reset (asynchronous, any time, including mid-command):
  - State returns to IDLE.
  - write, all load enables, busy, done and err go to 0.
  - readnum and writenum go to 0; vsel goes to 01; aluop, shift and asel go to 0; imm goes to 0.
  - No partial writeback occurs.
- Command accept: in IDLE with start=1 at a rising edge.
  - op, rd, rn, rm, shift_in and imm_in are latched.
  - The latched fields are held stable until the command returns to IDLE.
  - start is ignored while busy=1.
  - At least one IDLE cycle separates consecutive commands.
- Opcodes:
  - 000 MOVI: Rd = imm.
  - 001 MOV: Rd = sh(Rm).
  - 010 ADD: Rd = Rn + sh(Rm).
  - 011 CMP: status = Rn - sh(Rm).
  - 100 AND: Rd = Rn & sh(Rm).
  - 101 MVN: Rd = ~sh(Rm).
  - 110 and 111 are illegal.
- States: IDLE, LA, LB, EX, WB, WIMM, ILL.
- Per-state outputs (any output not listed is 0; vsel defaults to 01):
  - LA: readnum=rn, loada=1.
  - LB: readnum=rm, loadb=1.
  - EX:
    - loadc=1, aluop per opcode.
    - asel=1 for MOV/MVN, else 0.
    - CMP instead asserts loads=1 with loadc=0 and done=1.
  - WB: writenum=rd, vsel=01, write=1, done=1.
  - WIMM: writenum=rd, vsel=10, write=1, done=1.
- Sequences (each listed state lasts one cycle after accept; returns to IDLE at the edge after done):
  - MOVI: WIMM (latency 1).
  - MOV/MVN: LB, EX, WB (3).
  - ADD/AND: LA, LB, EX, WB (4).
  - CMP: LA, LB, EX (3).
- Width and bus rules:
  - readnum and writenum keep their last driven value in cycles where they are unused.
  - imm and shift are driven continuously from the latched values.

Optional Feature:
- Macro: SEQ_ILLEGAL_OP_EN.
- Defined:
  - Opcodes 110/111 enter ILL for one cycle with err=1 and done=1, then return to IDLE.
  - No load or write strobes are asserted.
- Undefined:
  - Opcodes 110/111 are treated as MOVI (WIMM sequence).
  - err is tied to 0.
  - The ILL state is not built.

Test Plan:
- Reset, then start with op=000, rd=3, imm_in=16'h00A5 -> next cycle: write=1, writenum=3, vsel=10, imm=00A5, done=1; idle after that.
- op=010, rn=1, rm=2, rd=5 -> the four cycles LA, LB, EX, WB produce:
  - LA: readnum=1, loada=1.
  - LB: readnum=2, loadb=1.
  - EX: loadc=1, aluop=00.
  - WB: write=1, writenum=5, done=1.
  - busy=1 for exactly 4 cycles.
- op=011, rn=4, rm=6 -> LA, LB, then EX with loads=1, loadc=0, aluop=01, done=1; write never asserted.
- op=001, rm=7, rd=0, shift_in=2'b01, with start held high throughout -> LB, then EX with asel=1, then WB with shift=01; after one IDLE cycle the second command is accepted.
- Reset asserted during the EX cycle of an ADD -> all strobes 0 immediately (asynchronous); the following cycles stay idle with no write.
- With SEQ_ILLEGAL_OP_EN, op=111 -> one cycle with err=1, done=1, write=0; without the macro -> WIMM write to rd.
